uart_tx_engine: RTL and testbench
=================================

// Module: uart_tx_engine
// PURPOSE
//  - Transmit half of the full UART. Serialises one byte per request onto tx:
//    start bit, DATA_BITS data bits LSB first, optional parity, one stop bit.
//  - The load strobe comes from the team's edge-detector pulse (one clk wide).
//  - Sits beside the receive engine and shares its baud divisor value, so both
//    directions run the same line rate.
// PARAMETERS
//  - BAUD_DIV   10417  clk cycles per bit (100 MHz / 9600 baud); legal >= 2
//  - DATA_BITS  8      data bits per frame; legal 7 or 8
// PORTS
//  - clk        in   1          system clock; all state updates on rising edge
//  - rst        in   1          synchronous, active-high reset
//  - load       in   1          one-cycle request; sampled only while tx_rdy=1
//  - data       in   DATA_BITS  byte to send; captured on the accepted load cycle
//  - parity_odd in   1          1=odd, 0=even parity (UART_TX_PARITY_EN only)
//  - tx         out  1          serial line; idle/mark = 1
//  - tx_rdy     out  1          1 = idle and able to accept load
//  - tx_done    out  1          one-cycle pulse at end of stop bit
// BEHAVIOUR
//  - Reset: tx=1, tx_rdy=1, tx_done=0; FSM=IDLE, baud counter=0, bit index=0.
//    rst wins over every other input on the same edge.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx=1, tx_rdy=1. load=1 on an edge: capture data into the shift
//    register and latch parity_odd. On that same edge: tx_rdy->0, tx->0, enter
//    START with baud counter=0. Latency from load edge to the start bit on tx is
//    one clk.
//  - Each bit holds tx for exactly BAUD_DIV clks. The counter runs
//    0..BAUD_DIV-1. At BAUD_DIV-1 it wraps to 0 and the FSM advances.
//  - DATA: tx = shift_reg[0]; shift right at the end of each bit. After bit
//    index DATA_BITS-1, go to PARITY (macro on) or STOP (macro off).
//  - PARITY: tx = ^captured_data ^ parity_odd_latched.
//  - STOP: tx=1 for BAUD_DIV clks. On the final clk edge: FSM->IDLE, tx_rdy->1,
//    tx_done=1 for exactly one cycle.
//  - Frame length: (DATA_BITS+2[+1]) * BAUD_DIV clks from the first start-bit
//    cycle to the tx_rdy rise.
//  - load while tx_rdy=0 is ignored. There is no queueing and no error flag.
//    data/parity_odd changes mid-frame have no effect.
//  - load on the first cycle tx_rdy is back to 1 is accepted. Back-to-back
//    frames therefore have no idle gap beyond the stop bit.
//  - tx is driven from a register (glitch-free). tx_rdy and tx_done are
//    registered.
//  - rst asserted mid-frame: next edge tx=1, tx_rdy=1, in-flight byte discarded.
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN.
//  - Defined: PARITY state is present and the parity_odd port exists. The frame
//    is 1+DATA_BITS+1+1 bits.
//  - Undefined: no PARITY state and no parity_odd port. The frame is
//    1+DATA_BITS+1 bits (8N1 at default).
// TESTING (bench uses BAUD_DIV=4, DATA_BITS=8)
//  - Reset then idle 20 clks -> tx=1, tx_rdy=1, tx_done=0 throughout.
//  - load with data=8'hA5, no parity -> tx bits 0,1,0,1,0,0,1,0,1,1, each
//    4 clks. tx_done at clk 40. tx_rdy high 40 clks after the start bit began.
//  - UART_TX_PARITY_EN, data=8'h03: parity_odd=0 -> parity bit 0;
//    parity_odd=1 -> 1. Frame is 44 clks.
//  - load pulses at clks 5, 12, 30 of a frame (data 8'hFF) -> ignored. The line
//    carries only the first byte, 8'h55.
//  - load asserted on the tx_rdy rise cycle with 8'h0F -> the next start bit
//    follows the stop bit with no extra idle clk.
//  - rst pulse during data bit 3 of 8'h00 -> tx=1 next clk, tx_rdy=1, no
//    tx_done. A new load afterwards sends a full correct frame.

Source files
------------

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// UartTxEngine (module uart_tx_engine)
// Transmit half of the UART. Serialises one byte per accepted load strobe as
// start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
// Each bit holds the line for BAUD_DIV clk cycles; the divisor value is shared
// with the receive engine so both directions run at the same line rate.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state and parity_odd port present (frame 1+N+1+1 bits)
//   undefined -> no parity bit, no parity_odd port (frame 1+N+1 bits, 8N1)
//
// Reset is synchronous and active-high; all outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int BAUD_DIV  = 10417,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 tx,
    output logic                 tx_rdy,
    output logic                 tx_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tx_next;
    logic                 rdy_next;
    logic                 done_next;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    // The parity bit is fixed when the byte is accepted, so later changes on
    // data or parity_odd cannot disturb a frame already in flight.
    logic                 par_bit;
    logic                 par_next;
`endif

    assign bit_end = (baud_cnt == CNT_LAST);

    // Next-state, bit sequencing and the next value of each registered output.
    // The line value is derived from the *next* state so tx changes on the
    // same edge as the state it belongs to, one clk after an accepted load.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift_reg;
        done_next     = 1'b0;
        tx_next       = 1'b1;
        rdy_next      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next      = par_bit;
`endif

        if (state != S_IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                if (load) begin
                    shift_next = data;
`ifdef UART_TX_PARITY_EN
                    par_next   = (^data) ^ parity_odd;
`endif
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = S_PARITY;
`else
                        state_next   = S_STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_IDLE:   tx_next = 1'b1;
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = par_next;
`endif
            S_STOP:   tx_next = 1'b1;
            default:  tx_next = 1'b1;
        endcase

        rdy_next = (state_next == S_IDLE);
    end

    // State and output registers; reset returns the line to mark and drops
    // any byte that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_rdy    <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            tx_rdy    <= rdy_next;
            tx_done   <= done_next;
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// Testbench for uart_tx_engine with BAUD_DIV=4, DATA_BITS=8.
// Directed frames with hand-written expected line patterns. Expected frames
// are stored LSB = first bit on the line (start bit), one entry per bit.
// Builds with or without UART_TX_PARITY_EN; the parity test exists only when
// the macro is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int BAUD = 4;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    // {stop, parity, data[7:0], start}; all these bytes have even popcount
    localparam logic [10:0] EXP_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] EXP_55 = 11'b1_0_01010101_0;
    localparam logic [10:0] EXP_0F = 11'b1_0_00001111_0;
    localparam logic [10:0] EXP_00 = 11'b1_0_00000000_0;
    localparam logic [10:0] EXP_03_EVEN = 11'b1_0_00000011_0;
    localparam logic [10:0] EXP_03_ODD  = 11'b1_1_00000011_0;
`else
    localparam int NB = 10;
    // {pad, stop, data[7:0], start}
    localparam logic [10:0] EXP_A5 = 11'b0_1_10100101_0;
    localparam logic [10:0] EXP_55 = 11'b0_1_01010101_0;
    localparam logic [10:0] EXP_0F = 11'b0_1_00001111_0;
    localparam logic [10:0] EXP_00 = 11'b0_1_00000000_0;
`endif

    localparam int FRM = NB * BAUD;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd;
`endif
    logic       tx;
    logic       tx_rdy;
    logic       tx_done;

    int checks;
    int errors;

    uart_tx_engine #(
        .BAUD_DIV  (BAUD),
        .DATA_BITS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .data       (data),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .tx         (tx),
        .tx_rdy     (tx_rdy),
        .tx_done    (tx_done)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got running required finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    // Samples tx/tx_rdy/tx_done on n consecutive falling edges, starting with
    // the current one. After each sample it drives load from load_at[i]
    // (with load_data when set), so a load raised before the call is dropped
    // after exactly one rising edge.
    task automatic capture(input int n, input logic [127:0] load_at,
                           input logic [7:0] load_data,
                           output logic [127:0] txw, output logic [127:0] rdyw,
                           output logic [127:0] donew);
        txw   = '0;
        rdyw  = '0;
        donew = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            txw[i]   = tx;
            rdyw[i]  = tx_rdy;
            donew[i] = tx_done;
            load     = load_at[i];
            if (load_at[i]) data = load_data;
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b1;
        data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, tx_rdy, tx_done} !== 3'b110)
            $display("[TB] FAIL reset_state got tx/rdy/done=%b required 110", {tx, tx_rdy, tx_done});
        load = 1'b0;
        rst  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, tx_rdy, tx_done} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL idle_after_reset clk=%0d got tx/rdy/done=%b required 110",
                         i, {tx, tx_rdy, tx_done});
            end
        end
    endtask

    task automatic test_frame_a5();
        logic [127:0] txw, rdyw, donew;
        @(negedge clk);
        data = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        capture(FRM + 2, '0, 8'h00, txw, rdyw, donew);
        for (int k = 0; k < FRM; k++) begin
            checks++;
            if ({txw[k], rdyw[k], donew[k]} !== {EXP_A5[k / BAUD], 2'b00}) begin
                errors++;
                $display("[TB] FAIL frame_a5 clk=%0d got tx/rdy/done=%b required %b",
                         k, {txw[k], rdyw[k], donew[k]}, {EXP_A5[k / BAUD], 2'b00});
            end
        end
        checks++;
        if ({txw[FRM], rdyw[FRM], donew[FRM]} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL frame_a5_end got tx/rdy/done=%b required 111",
                     {txw[FRM], rdyw[FRM], donew[FRM]});
        end
        checks++;
        if ({txw[FRM+1], rdyw[FRM+1], donew[FRM+1]} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL frame_a5_done_pulse got tx/rdy/done=%b required 110",
                     {txw[FRM+1], rdyw[FRM+1], donew[FRM+1]});
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [127:0] txw, rdyw, donew;
        logic [10:0]  exp_frame;
        for (int p = 0; p < 2; p++) begin
            exp_frame = (p == 0) ? EXP_03_EVEN : EXP_03_ODD;
            @(negedge clk);
            data       = 8'h03;
            parity_odd = (p == 1);
            load       = 1'b1;
            @(negedge clk);
            capture(FRM + 2, '0, 8'h00, txw, rdyw, donew);
            parity_odd = ~parity_odd;
            for (int k = 0; k < FRM; k++) begin
                checks++;
                if ({txw[k], rdyw[k], donew[k]} !== {exp_frame[k / BAUD], 2'b00}) begin
                    errors++;
                    $display("[TB] FAIL parity_%0d clk=%0d got tx/rdy/done=%b required %b",
                             p, k, {txw[k], rdyw[k], donew[k]}, {exp_frame[k / BAUD], 2'b00});
                end
            end
            checks++;
            if ({txw[FRM], rdyw[FRM], donew[FRM]} !== 3'b111) begin
                errors++;
                $display("[TB] FAIL parity_%0d_len got tx/rdy/done=%b required 111",
                         p, {txw[FRM], rdyw[FRM], donew[FRM]});
            end
            parity_odd = 1'b0;
        end
    endtask
`endif

    task automatic test_ignored_load();
        logic [127:0] txw, rdyw, donew;
        logic [127:0] load_at;
        load_at     = '0;
        load_at[5]  = 1'b1;
        load_at[12] = 1'b1;
        load_at[30] = 1'b1;
        @(negedge clk);
        data = 8'h55;
        load = 1'b1;
        @(negedge clk);
        capture(FRM + 8, load_at, 8'hFF, txw, rdyw, donew);
        for (int k = 0; k < FRM; k++) begin
            checks++;
            if ({txw[k], rdyw[k], donew[k]} !== {EXP_55[k / BAUD], 2'b00}) begin
                errors++;
                $display("[TB] FAIL ignored_load clk=%0d got tx/rdy/done=%b required %b",
                         k, {txw[k], rdyw[k], donew[k]}, {EXP_55[k / BAUD], 2'b00});
            end
        end
        checks++;
        if ({txw[FRM], rdyw[FRM], donew[FRM]} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL ignored_load_end got tx/rdy/done=%b required 111",
                     {txw[FRM], rdyw[FRM], donew[FRM]});
        end
        for (int k = FRM + 1; k < FRM + 8; k++) begin
            checks++;
            if ({txw[k], rdyw[k], donew[k]} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL ignored_load_no_queue clk=%0d got tx/rdy/done=%b required 110",
                         k, {txw[k], rdyw[k], donew[k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] txw, rdyw, donew;
        logic [127:0] load_at;
        load_at      = '0;
        load_at[FRM] = 1'b1;
        @(negedge clk);
        data = 8'hA5;
        load = 1'b1;
        @(negedge clk);
        capture(2 * FRM + 2, load_at, 8'h0F, txw, rdyw, donew);
        for (int k = 0; k < FRM; k++) begin
            checks++;
            if (txw[k] !== EXP_A5[k / BAUD]) begin
                errors++;
                $display("[TB] FAIL b2b_first clk=%0d got tx=%b required %b",
                         k, txw[k], EXP_A5[k / BAUD]);
            end
        end
        checks++;
        if ({txw[FRM], rdyw[FRM], donew[FRM]} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL b2b_rdy_rise got tx/rdy/done=%b required 111",
                     {txw[FRM], rdyw[FRM], donew[FRM]});
        end
        // The load sampled on the tx_rdy-rise cycle starts the next frame on
        // the very next clk.
        for (int j = 0; j < FRM; j++) begin
            checks++;
            if ({txw[FRM+1+j], rdyw[FRM+1+j], donew[FRM+1+j]} !== {EXP_0F[j / BAUD], 2'b00}) begin
                errors++;
                $display("[TB] FAIL b2b_second clk=%0d got tx/rdy/done=%b required %b",
                         j, {txw[FRM+1+j], rdyw[FRM+1+j], donew[FRM+1+j]},
                         {EXP_0F[j / BAUD], 2'b00});
            end
        end
        checks++;
        if ({txw[2*FRM+1], rdyw[2*FRM+1], donew[2*FRM+1]} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL b2b_second_end got tx/rdy/done=%b required 111",
                     {txw[2*FRM+1], rdyw[2*FRM+1], donew[2*FRM+1]});
        end
    endtask

    task automatic test_reset_midframe();
        logic [127:0] txw, rdyw, donew;
        @(negedge clk);
        data = 8'h00;
        load = 1'b1;
        @(negedge clk);
        // samples 0..17 end in the middle of data bit 3 (clks 16..19)
        capture(18, '0, 8'h00, txw, rdyw, donew);
        for (int k = 0; k < 18; k++) begin
            checks++;
            if ({txw[k], rdyw[k]} !== {EXP_00[k / BAUD], 1'b0}) begin
                errors++;
                $display("[TB] FAIL midreset_pre clk=%0d got tx/rdy=%b required %b",
                         k, {txw[k], rdyw[k]}, {EXP_00[k / BAUD], 1'b0});
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx, tx_rdy, tx_done} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL midreset_line got tx/rdy/done=%b required 110", {tx, tx_rdy, tx_done});
        end
        for (int i = 0; i < FRM; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, tx_rdy, tx_done} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL midreset_quiet clk=%0d got tx/rdy/done=%b required 110",
                         i, {tx, tx_rdy, tx_done});
            end
        end
        test_frame_a5();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        load   = 1'b0;
        data   = 8'h00;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        test_reset();
        test_frame_a5();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_ignored_load();
        test_back_to_back();
        test_reset_midframe();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
